// File: rtl/axi_lite_regmap_gen.sv
// AXI4-Lite slave register file with configurable register count and width.
// Supports byte strobes, read-only registers fed from reg_in, write-1-to-clear
// status registers fed from hw_set, SLVERR on out-of-range addresses and
// per-register write/read access pulses. Write and read channels are independent.
module axi_lite_regmap_gen #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS = 8,
  parameter logic [63:0] RO_MASK = 64'd0,
  parameter logic [63:0] W1C_MASK = 64'd0,
  parameter logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] RESET_VALUE =
    {(NUM_REGS*C_S_AXI_DATA_WIDTH){1'b0}}
) (
  input  logic                                     ACLK,
  input  logic                                     ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                               S_AXI_AWPROT,
  input  logic                                     S_AXI_AWVALID,
  output logic                                     S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                                     S_AXI_WVALID,
  output logic                                     S_AXI_WREADY,
  output logic [1:0]                               S_AXI_BRESP,
  output logic                                     S_AXI_BVALID,
  input  logic                                     S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                               S_AXI_ARPROT,
  input  logic                                     S_AXI_ARVALID,
  output logic                                     S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                               S_AXI_RRESP,
  output logic                                     S_AXI_RVALID,
  input  logic                                     S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   reg_in,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   hw_set,
  output logic [NUM_REGS-1:0]                      wr_pulse,
  output logic [NUM_REGS-1:0]                      rd_pulse
);

  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int AW   = C_S_AXI_ADDR_WIDTH;
  localparam int SW   = DW / 8;
  localparam int LSB  = $clog2(SW);
  localparam int IDXW = AW - LSB;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } r_state_t;

  // Register index is in range when it addresses one of the implemented registers.
  function automatic logic idx_in_range(input logic [IDXW-1:0] idx);
    logic [31:0] idx_ext;
    idx_ext = 32'(idx);
    return (idx_ext < 32'(NUM_REGS));
  endfunction

  // Expand byte strobes into a bit mask.
  function automatic logic [DW-1:0] strb_mask(input logic [SW-1:0] strb);
    logic [DW-1:0] m;
    m = {DW{1'b0}};
    for (int k = 0; k < SW; k++) begin
      m[k*8 +: 8] = {8{strb[k]}};
    end
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  w_state_t            w_state_r;
  w_state_t            w_next_s;
  logic                awready_r;
  logic                wready_r;
  logic                bvalid_r;
  logic [1:0]          bresp_r;
  logic [IDXW-1:0]     aw_idx_r;
  logic [DW-1:0]       wdata_r;
  logic [SW-1:0]       wstrb_r;
  logic [NUM_REGS-1:0] wr_pulse_r;

  logic                aw_hs_s;
  logic                w_hs_s;
  logic                commit_s;
  logic [IDXW-1:0]     wr_idx_s;
  logic [DW-1:0]       wr_data_s;
  logic [DW-1:0]       wr_mask_s;
  logic                wr_ok_s;
  logic [NUM_REGS-1:0] wr_hit_s;

  logic [DW-1:0]       regs_r     [NUM_REGS];
  logic [DW-1:0]       reg_next_s [NUM_REGS];

  assign aw_hs_s   = S_AXI_AWVALID & awready_r;
  assign w_hs_s    = S_AXI_WVALID & wready_r;
  // Fresh handshake data takes precedence over the latched half of the pair.
  assign wr_idx_s  = aw_hs_s ? S_AXI_AWADDR[AW-1:LSB] : aw_idx_r;
  assign wr_data_s = w_hs_s ? S_AXI_WDATA : wdata_r;
  assign wr_mask_s = strb_mask(w_hs_s ? S_AXI_WSTRB : wstrb_r);
  assign wr_ok_s   = idx_in_range(wr_idx_s);
  assign commit_s  = (w_next_s == W_RESP) && (w_state_r != W_RESP);

  // Write FSM state register.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_state_r <= W_IDLE;
    end else begin
      w_state_r <= w_next_s;
    end
  end

  // Write FSM next-state: address and data may arrive together or in either order.
  always_comb begin
    w_next_s = w_state_r;
    case (w_state_r)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          w_next_s = W_RESP;
        end else if (aw_hs_s) begin
          w_next_s = W_HAVE_A;
        end else if (w_hs_s) begin
          w_next_s = W_HAVE_D;
        end else begin
          w_next_s = W_IDLE;
        end
      end
      W_HAVE_A: begin
        if (w_hs_s) begin
          w_next_s = W_RESP;
        end else begin
          w_next_s = W_HAVE_A;
        end
      end
      W_HAVE_D: begin
        if (aw_hs_s) begin
          w_next_s = W_RESP;
        end else begin
          w_next_s = W_HAVE_D;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          w_next_s = W_IDLE;
        end else begin
          w_next_s = W_RESP;
        end
      end
      default: begin
        w_next_s = W_IDLE;
      end
    endcase
  end

  // Latch whichever half of the write transaction arrives first.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_idx_r <= {IDXW{1'b0}};
      wdata_r  <= {DW{1'b0}};
      wstrb_r  <= {SW{1'b0}};
    end else begin
      if (aw_hs_s) begin
        aw_idx_r <= S_AXI_AWADDR[AW-1:LSB];
      end else begin
        aw_idx_r <= aw_idx_r;
      end
      if (w_hs_s) begin
        wdata_r <= S_AXI_WDATA;
        wstrb_r <= S_AXI_WSTRB;
      end else begin
        wdata_r <= wdata_r;
        wstrb_r <= wstrb_r;
      end
    end
  end

  // Which register (if any) the committing write targets; RO registers still pulse.
  always_comb begin
    wr_hit_s = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_hit_s[i] = commit_s & wr_ok_s & (wr_idx_s == IDXW'(i));
    end
  end

  // Write channel outputs registered from the next state so they follow it by one edge.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
      wr_pulse_r <= {NUM_REGS{1'b0}};
    end else begin
      awready_r  <= (w_next_s == W_IDLE) || (w_next_s == W_HAVE_D);
      wready_r   <= (w_next_s == W_IDLE) || (w_next_s == W_HAVE_A);
      bvalid_r   <= (w_next_s == W_RESP);
      if (commit_s) begin
        bresp_r <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
      end else begin
        bresp_r <= bresp_r;
      end
      wr_pulse_r <= wr_hit_s;
    end
  end

  // Per-register next value: RO holds, W1C clears written ones then ORs hw_set, normal merges bytes.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_next_s[i] = regs_r[i];
      if (RO_MASK[i]) begin
        reg_next_s[i] = regs_r[i];
      end else if (W1C_MASK[i]) begin
        reg_next_s[i] = (regs_r[i] & ~(wr_hit_s[i] ? (wr_data_s & wr_mask_s) : {DW{1'b0}}))
                        | hw_set[i*DW +: DW];
      end else if (wr_hit_s[i]) begin
        reg_next_s[i] = (regs_r[i] & ~wr_mask_s) | (wr_data_s & wr_mask_s);
      end else begin
        reg_next_s[i] = regs_r[i];
      end
    end
  end

  // Register storage.
  always_ff @(posedge ACLK) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!ARESETN) begin
        regs_r[i] <= RESET_VALUE[i*DW +: DW];
      end else begin
        regs_r[i] <= reg_next_s[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  r_state_t            r_state_r;
  r_state_t            r_next_s;
  logic                arready_r;
  logic                rvalid_r;
  logic [DW-1:0]       rdata_r;
  logic [1:0]          rresp_r;
  logic [NUM_REGS-1:0] rd_pulse_r;

  logic                ar_hs_s;
  logic [IDXW-1:0]     rd_idx_s;
  logic                rd_ok_s;
  logic [DW-1:0]       rd_val_s;
  logic [NUM_REGS-1:0] rd_hit_s;

  assign ar_hs_s  = S_AXI_ARVALID & arready_r;
  assign rd_idx_s = S_AXI_ARADDR[AW-1:LSB];
  assign rd_ok_s  = idx_in_range(rd_idx_s);

  // Read FSM state register.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state_r <= R_IDLE;
    end else begin
      r_state_r <= r_next_s;
    end
  end

  // Read FSM next-state: one read outstanding at a time.
  always_comb begin
    r_next_s = r_state_r;
    case (r_state_r)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_next_s = R_RESP;
        end else begin
          r_next_s = R_IDLE;
        end
      end
      R_RESP: begin
        if (S_AXI_RREADY) begin
          r_next_s = R_IDLE;
        end else begin
          r_next_s = R_RESP;
        end
      end
      default: begin
        r_next_s = R_IDLE;
      end
    endcase
  end

  // Read data mux: RO registers return the live reg_in slice, others the stored value.
  always_comb begin
    rd_val_s = {DW{1'b0}};
    rd_hit_s = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx_s == IDXW'(i)) begin
        rd_val_s = RO_MASK[i] ? reg_in[i*DW +: DW] : regs_r[i];
      end else begin
        rd_val_s = rd_val_s;
      end
      rd_hit_s[i] = ar_hs_s & rd_ok_s & (rd_idx_s == IDXW'(i));
    end
  end

  // Read channel outputs; data and response are captured at the address handshake.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rdata_r    <= {DW{1'b0}};
      rresp_r    <= RESP_OKAY;
      rd_pulse_r <= {NUM_REGS{1'b0}};
    end else begin
      arready_r <= (r_next_s == R_IDLE);
      rvalid_r  <= (r_next_s == R_RESP);
      if (ar_hs_s) begin
        rdata_r <= rd_ok_s ? rd_val_s : {DW{1'b0}};
        rresp_r <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
      end else begin
        rdata_r <= rdata_r;
        rresp_r <= rresp_r;
      end
      rd_pulse_r <= rd_hit_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign S_AXI_AWREADY = awready_r;
  assign S_AXI_WREADY  = wready_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_ARREADY = arready_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RDATA   = rdata_r;
  assign S_AXI_RRESP   = rresp_r;
  assign wr_pulse      = wr_pulse_r;
  assign rd_pulse      = rd_pulse_r;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DW +: DW] = regs_r[g];
  end

  // Protection bits, sub-word address bits and the unused slices of reg_in/hw_set
  // carry no meaning for this register file.
  logic unused_s;
  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0],
                      S_AXI_ARADDR[LSB-1:0], reg_in, hw_set};

endmodule

// File: tb/tb_axi_lite_regmap_gen.sv
// Self-checking bench for axi_lite_regmap_gen: directed scenarios plus randomized
// traffic, all checked against a behavioural register-file model.
module tb_axi_lite_regmap_gen;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 8;
  localparam logic [63:0] RO_M  = 64'h4;
  localparam logic [63:0] W1C_M = 64'h8;
  localparam logic [NR*DW-1:0] RV = {32'h7777_0007, 32'h6666_0006, 32'h5555_0005,
                                     32'h4444_0004, 32'h0000_0000, 32'hDEAD_0002,
                                     32'h1111_1111, 32'h0000_00A5};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic aresetn;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [NR*DW-1:0] reg_out, reg_in, hw_set;
  logic [NR-1:0] wr_pulse, rd_pulse;

  axi_lite_regmap_gen #(
    .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .NUM_REGS(NR),
    .RO_MASK(RO_M), .W1C_MASK(W1C_M), .RESET_VALUE(RV)
  ) dut (
    .ACLK(clk), .ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .reg_in(reg_in), .hw_set(hw_set),
    .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
  );

  int total = 0;
  int bad = 0;
  logic [DW-1:0] model_regs [NR];
  int wr_cnt [NR];
  int rd_cnt [NR];

  // Count cycles each access pulse is high.
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (wr_pulse[i]) wr_cnt[i]++;
      if (rd_pulse[i]) rd_cnt[i]++;
    end
  end

  // ---------------- reference model ----------------
  function automatic void model_reset();
    logic [NR*DW-1:0] rv_v;
    rv_v = RV;
    for (int i = 0; i < NR; i++) model_regs[i] = rv_v[i*DW +: DW];
  endfunction

  function automatic logic [NR*DW-1:0] model_vec();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = model_regs[i];
    return v;
  endfunction

  function automatic int addr_idx(input logic [AW-1:0] a);
    return int'(a) / 4;
  endfunction

  function automatic logic [1:0] model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                             input logic [3:0] s);
    int idx;
    idx = addr_idx(a);
    if (idx >= NR) return 2'b10;
    if (RO_M[idx]) return 2'b00;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) begin
        if (W1C_M[idx]) model_regs[idx][b*8 +: 8] = model_regs[idx][b*8 +: 8] & ~d[b*8 +: 8];
        else model_regs[idx][b*8 +: 8] = d[b*8 +: 8];
      end
    end
    return 2'b00;
  endfunction

  function automatic void model_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                                     output logic [1:0] r);
    int idx;
    idx = addr_idx(a);
    if (idx >= NR) begin
      d = 32'h0; r = 2'b10;
    end else begin
      d = RO_M[idx] ? reg_in[idx*DW +: DW] : model_regs[idx];
      r = 2'b00;
    end
  endfunction

  function automatic logic [NR-1:0] exp_pulse(input logic [AW-1:0] a);
    logic [NR-1:0] p;
    p = '0;
    if (addr_idx(a) < NR) p[addr_idx(a)] = 1'b1;
    return p;
  endfunction

  // ---------------- bus drivers (no checking) ----------------
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly,
                          output logic [1:0] resp, output logic lat_ok, output logic stable_ok,
                          output logic [NR-1:0] pulse, output logic tmo);
    int c;
    logic aw_done, w_done, hs_aw, hs_w, early;
    c = 0; aw_done = 1'b0; w_done = 1'b0; early = 1'b0;
    tmo = 1'b0; stable_ok = 1'b1; lat_ok = 1'b0; resp = 2'b11; pulse = '0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done)) begin
      if (c >= 40) begin tmo = 1'b1; break; end
      awvalid = !aw_done && (c >= aw_dly);
      wvalid  = !w_done && (c >= w_dly);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      if (bvalid) early = 1'b1;
      @(negedge clk);
      if (hs_aw) aw_done = 1'b1;
      if (hs_w) w_done = 1'b1;
      c++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!tmo) begin
      lat_ok = bvalid && !early;
      resp = bresp;
      pulse = wr_pulse;
      for (int k = 0; k < b_dly; k++) begin
        @(negedge clk);
        if (bvalid !== 1'b1 || bresp !== resp) stable_ok = 1'b0;
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] resp,
                         output logic lat_ok, output logic [NR-1:0] pulse, output logic tmo);
    int c;
    c = 0; tmo = 1'b0; d = '0; resp = 2'b11; lat_ok = 1'b0; pulse = '0;
    araddr = a; arvalid = 1'b1;
    while (!arready) begin
      if (c >= 40) begin tmo = 1'b1; break; end
      @(negedge clk);
      c++;
    end
    if (!tmo) begin
      @(negedge clk);
      arvalid = 1'b0;
      lat_ok = rvalid; d = rdata; resp = rresp; pulse = rd_pulse;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
    end else begin
      arvalid = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    aresetn = 1'b0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    reg_in = '0; hw_set = '0;
    model_reset();
    repeat (3) @(negedge clk);
    total++; if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin bad++; $display("FAIL reset_hs got=%b exp=00000", {awready, wready, bvalid, arready, rvalid}); end
    total++; if ({bresp, rresp, rdata} !== 36'h0) begin bad++; $display("FAIL reset_resp got=%h exp=0", {bresp, rresp, rdata}); end
    total++; if ({wr_pulse, rd_pulse} !== 16'h0) begin bad++; $display("FAIL reset_pulse got=%h exp=0", {wr_pulse, rd_pulse}); end
    total++; if (reg_out !== model_vec()) begin bad++; $display("FAIL reset_regs got=%h exp=%h", reg_out, model_vec()); end
    aresetn = 1'b1;
    @(negedge clk);
    total++; if ({awready, wready, arready} !== 3'b111) begin bad++; $display("FAIL reset_ready got=%b exp=111", {awready, wready, arready}); end
  endtask

  task automatic test_basic();
    logic [1:0] r, er; logic lat, st, to; logic [NR-1:0] p; logic [DW-1:0] d, ed;
    int wc0 [NR]; int rc0 [NR];
    for (int i = 0; i < NR; i++) begin wc0[i] = wr_cnt[i]; rc0[i] = rd_cnt[i]; end
    for (int k = 0; k < 4; k++) begin
      do_write(AW'(k*4), DW'(k+1), 4'hF, 0, 0, 0, r, lat, st, p, to);
      er = model_write(AW'(k*4), DW'(k+1), 4'hF);
      total++; if (to !== 1'b0 || r !== er) begin bad++; $display("FAIL basic_bresp[%0d] got=%b exp=%b to=%b", k, r, er, to); end
      total++; if (lat !== 1'b1 || p !== exp_pulse(AW'(k*4))) begin bad++; $display("FAIL basic_wpulse[%0d] got=%b exp=%b lat=%b", k, p, exp_pulse(AW'(k*4)), lat); end
    end
    for (int k = 0; k < 4; k++) begin
      do_read(AW'(k*4), d, r, lat, p, to);
      model_read(AW'(k*4), ed, er);
      total++; if (to !== 1'b0 || lat !== 1'b1 || d !== ed || r !== er) begin bad++; $display("FAIL basic_read[%0d] got=%h/%b exp=%h/%b lat=%b", k, d, r, ed, er, lat); end
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      total++; if (wr_cnt[k] - wc0[k] !== 1 || rd_cnt[k] - rc0[k] !== 1) begin bad++; $display("FAIL basic_pulse_count[%0d] got=%0d/%0d exp=1/1", k, wr_cnt[k] - wc0[k], rd_cnt[k] - rc0[k]); end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] r, er; logic lat, st, to; logic [NR-1:0] p; logic [DW-1:0] d, ed;
    do_write(6'h04, 32'hAABBCCDD, 4'hF, 0, 0, 0, r, lat, st, p, to);
    er = model_write(6'h04, 32'hAABBCCDD, 4'hF);
    do_write(6'h04, 32'h11223344, 4'b0101, 0, 0, 0, r, lat, st, p, to);
    er = model_write(6'h04, 32'h11223344, 4'b0101);
    do_read(6'h04, d, r, lat, p, to);
    model_read(6'h04, ed, er);
    total++; if (d !== ed || r !== er) begin bad++; $display("FAIL strobe_read got=%h/%b exp=%h/%b", d, r, ed, er); end
  endtask

  task automatic test_handshake_order();
    logic [1:0] r, er; logic lat, st, to; logic [NR-1:0] p; logic [DW-1:0] d, ed, v;
    v = $urandom;
    do_write(6'h08 + 6'h0C, v, 4'hF, 0, 3, 5, r, lat, st, p, to);  // AW leads W by 3 cycles
    er = model_write(6'h14, v, 4'hF);
    total++; if (to !== 1'b0 || lat !== 1'b1 || st !== 1'b1 || r !== er) begin bad++; $display("FAIL aw_first got=lat%b st%b r%b exp=lat1 st1 r%b", lat, st, r, er); end
    v = $urandom;
    do_write(6'h10, v, 4'hF, 2, 0, 5, r, lat, st, p, to);          // W leads AW by 2 cycles
    er = model_write(6'h10, v, 4'hF);
    total++; if (to !== 1'b0 || lat !== 1'b1 || st !== 1'b1 || r !== er) begin bad++; $display("FAIL w_first got=lat%b st%b r%b exp=lat1 st1 r%b", lat, st, r, er); end
    do_read(6'h10, d, r, lat, p, to);
    model_read(6'h10, ed, er);
    total++; if (d !== ed || r !== er) begin bad++; $display("FAIL order_read got=%h exp=%h", d, ed); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] r, er; logic lat, st, to; logic [NR-1:0] p; logic [DW-1:0] d, ed;
    do_write(6'h20, $urandom, 4'hF, 0, 0, 0, r, lat, st, p, to);
    er = model_write(6'h20, 32'h0, 4'hF);
    total++; if (r !== er || p !== '0) begin bad++; $display("FAIL oor_write got=%b/%b exp=%b/0", r, p, er); end
    total++; if (reg_out !== model_vec()) begin bad++; $display("FAIL oor_regs got=%h exp=%h", reg_out, model_vec()); end
    do_read(6'h3D, d, r, lat, p, to);
    model_read(6'h3D, ed, er);
    total++; if (d !== ed || r !== er || p !== '0) begin bad++; $display("FAIL oor_read got=%h/%b/%b exp=%h/%b/0", d, r, p, ed, er); end
  endtask

  task automatic test_ro();
    logic [1:0] r, er; logic lat, st, to; logic [NR-1:0] p; logic [DW-1:0] d, ed;
    reg_in[2*DW +: DW] = 32'hCAFEF00D;
    do_write(6'h08, 32'h0, 4'hF, 0, 0, 0, r, lat, st, p, to);
    er = model_write(6'h08, 32'h0, 4'hF);
    total++; if (r !== er || p !== exp_pulse(6'h08)) begin bad++; $display("FAIL ro_write got=%b/%b exp=%b/%b", r, p, er, exp_pulse(6'h08)); end
    do_read(6'h08, d, r, lat, p, to);
    model_read(6'h08, ed, er);
    total++; if (d !== ed || r !== er) begin bad++; $display("FAIL ro_read got=%h exp=%h", d, ed); end
  endtask

  task automatic test_w1c();
    logic [1:0] r, er; logic lat, st, to; logic [NR-1:0] p; logic [DW-1:0] d, ed;
    do_write(6'h0C, 32'hFFFFFFFF, 4'hF, 0, 0, 0, r, lat, st, p, to);
    er = model_write(6'h0C, 32'hFFFFFFFF, 4'hF);
    hw_set[3*DW +: DW] = 32'hF0;
    @(negedge clk);
    hw_set = '0;
    model_regs[3] = model_regs[3] | 32'hF0;
    total++; if (reg_out[3*DW +: DW] !== model_regs[3]) begin bad++; $display("FAIL w1c_set got=%h exp=%h", reg_out[3*DW +: DW], model_regs[3]); end
    total++; if ({awready, wready} !== 2'b11) begin bad++; $display("FAIL w1c_ready got=%b exp=11", {awready, wready}); end
    awaddr = 6'h0C; wdata = 32'h30; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    hw_set[3*DW +: DW] = 32'h10;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; hw_set = '0;
    model_regs[3] = (model_regs[3] & ~32'h30) | 32'h10;
    total++; if (bvalid !== 1'b1) begin bad++; $display("FAIL w1c_bvalid got=%b exp=1", bvalid); end
    bready = 1'b1; @(negedge clk); bready = 1'b0;
    do_read(6'h0C, d, r, lat, p, to);
    model_read(6'h0C, ed, er);
    total++; if (d !== ed || d !== 32'hD0) begin bad++; $display("FAIL w1c_read got=%h exp=%h", d, ed); end
  endtask

  task automatic test_concurrent();
    logic [DW-1:0] old_v, v, d, ed; logic [1:0] r, er; logic lat, to; logic [NR-1:0] p;
    old_v = model_regs[5]; v = $urandom;
    awaddr = 6'h14; wdata = v; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 6'h14; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    er = model_write(6'h14, v, 4'hF);
    total++; if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== old_v) begin bad++; $display("FAIL concurrent_read got=%h rv%b bv%b exp=%h", rdata, rvalid, bvalid, old_v); end
    bready = 1'b1; rready = 1'b1; @(negedge clk); bready = 1'b0; rready = 1'b0;
    do_read(6'h14, d, r, lat, p, to);
    model_read(6'h14, ed, er);
    total++; if (d !== ed) begin bad++; $display("FAIL concurrent_after got=%h exp=%h", d, ed); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a; logic [DW-1:0] v, d, ed; logic [3:0] s;
    logic [1:0] r, er; logic lat, st, to; logic [NR-1:0] p;
    for (int n = 0; n < 30; n++) begin
      a = AW'($urandom_range(0, 63)); v = $urandom; s = 4'($urandom_range(0, 15));
      reg_in[2*DW +: DW] = $urandom;
      do_write(a, v, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), r, lat, st, p, to);
      er = model_write(a, v, s);
      total++; if (to !== 1'b0 || lat !== 1'b1 || st !== 1'b1 || r !== er || p !== exp_pulse(a)) begin bad++; $display("FAIL rand_write[%0d] a=%h got=%b/%b lat%b st%b exp=%b/%b", n, a, r, p, lat, st, er, exp_pulse(a)); end
      a = AW'($urandom_range(0, 63));
      do_read(a, d, r, lat, p, to);
      model_read(a, ed, er);
      total++; if (to !== 1'b0 || lat !== 1'b1 || d !== ed || r !== er || p !== exp_pulse(a)) begin bad++; $display("FAIL rand_read[%0d] a=%h got=%h/%b/%b exp=%h/%b/%b", n, a, d, r, p, ed, er, exp_pulse(a)); end
    end
    total++; if (reg_out !== model_vec()) begin bad++; $display("FAIL rand_regs got=%h exp=%h", reg_out, model_vec()); end
  endtask

  task automatic test_back_to_back();
    int ones, rc0, dbad;
    ones = 0; dbad = 0; rc0 = rd_cnt[1];
    araddr = 6'h04; arvalid = 1'b1; rready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rvalid) begin
        ones++;
        if (rdata !== model_regs[1]) dbad++;
      end
    end
    arvalid = 1'b0;
    @(negedge clk);
    rready = 1'b0;
    @(negedge clk);
    total++; if (ones !== 5 || dbad !== 0) begin bad++; $display("FAIL b2b_rvalid got=%0d bad_data=%0d exp=5", ones, dbad); end
    total++; if (rd_cnt[1] - rc0 !== 5) begin bad++; $display("FAIL b2b_pulses got=%0d exp=5", rd_cnt[1] - rc0); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] r, er; logic lat, st, to; logic [NR-1:0] p; logic [DW-1:0] d, ed, v;
    awaddr = 6'h00; awvalid = 1'b1; araddr = 6'h04; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; arvalid = 1'b0;
    total++; if (rvalid !== 1'b1 || awready !== 1'b0) begin bad++; $display("FAIL mid_setup got=rv%b awr%b exp=rv1 awr0", rvalid, awready); end
    aresetn = 1'b0;
    @(negedge clk);
    model_reset();
    total++; if ({awready, wready, bvalid, arready, rvalid} !== 5'b0 || rdata !== 32'h0) begin bad++; $display("FAIL mid_reset got=%b rdata=%h exp=00000/0", {awready, wready, bvalid, arready, rvalid}, rdata); end
    total++; if (reg_out !== model_vec()) begin bad++; $display("FAIL mid_regs got=%h exp=%h", reg_out, model_vec()); end
    aresetn = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bvalid !== 1'b0 || rvalid !== 1'b0) begin bad++; $display("FAIL mid_abandon got=bv%b rv%b exp=0/0", bvalid, rvalid); end
    v = $urandom;
    do_write(6'h04, v, 4'hF, 0, 0, 0, r, lat, st, p, to);
    er = model_write(6'h04, v, 4'hF);
    total++; if (to !== 1'b0 || lat !== 1'b1 || r !== er || p !== exp_pulse(6'h04)) begin bad++; $display("FAIL mid_fresh_write got=%b/%b lat%b exp=%b", r, p, lat, er); end
    do_read(6'h04, d, r, lat, p, to);
    model_read(6'h04, ed, er);
    total++; if (d !== ed) begin bad++; $display("FAIL mid_fresh_read got=%h exp=%h", d, ed); end
    do_read(6'h00, d, r, lat, p, to);
    model_read(6'h00, ed, er);
    total++; if (d !== ed) begin bad++; $display("FAIL mid_reg0 got=%h exp=%h", d, ed); end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin wr_cnt[i] = 0; rd_cnt[i] = 0; end
    @(negedge clk);
    test_reset();
    test_basic();
    test_strobe();
    test_handshake_order();
    test_out_of_range();
    test_ro();
    test_w1c();
    test_concurrent();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_regmap_gen.md
Name: axi_lite_regmap_gen

Overview:
- Parametrised AXI4-Lite slave register file; next generation of the fixed four-register, 32-bit regmap.
- Adds configurable register count and data width, byte strobes and per-register read-only / write-1-to-clear modes.
- Adds SLVERR decode, independent AW/W acceptance and per-register access pulses.
- Sits behind the block-design AXI interconnect and exposes control/status registers to PL logic.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, bus and register width; legal values 32 or 64.
- C_S_AXI_ADDR_WIDTH, 6, byte address width; must cover NUM_REGS*(DATA_WIDTH/8).
- NUM_REGS, 8, number of registers, 1..64.
- RO_MASK, 0, bit i=1: register i reads reg_in slice i; writes ignored (OKAY response).
- W1C_MASK, 0, bit i=1: register i is status; written 1 bits clear, hw_set bits set.
- RESET_VALUE, 0, flat NUM_REGS*DATA_WIDTH vector of reset values.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  synchronous active-low reset
- S_AXI_AWADDR  in  ADDR_W  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake
- S_AXI_WDATA  in  DATA_W  write data
- S_AXI_WSTRB  in  DATA_W/8  byte strobes
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake
- S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake
- S_AXI_ARADDR  in  ADDR_W  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake
- S_AXI_RDATA  out  DATA_W  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake
- reg_out  out  NUM_REGS*DATA_W  current register contents
- reg_in  in  NUM_REGS*DATA_W  read-only sources (used where RO_MASK=1)
- hw_set  in  NUM_REGS*DATA_W  W1C set bits (used where W1C_MASK=1)
- wr_pulse  out  NUM_REGS  one-cycle pulse on register write commit
- rd_pulse  out  NUM_REGS  one-cycle pulse on register read accept

Behaviour:
- Reset (ARESETN=0 at rising ACLK), regardless of transaction in progress:
  - all READY/VALID outputs 0; BRESP, RRESP, RDATA 0; pulses 0.
  - registers load RESET_VALUE; both FSMs return to IDLE.
  - in-flight transactions are abandoned with no response.
- Decode:
  - LSB = log2(DATA_W/8); idx = addr[ADDR_W-1:LSB]; low address bits ignored.
  - idx >= NUM_REGS is out-of-range.
- Write FSM states: W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP.
  - AWREADY=1 in W_IDLE and W_HAVE_D. WREADY=1 in W_IDLE and W_HAVE_A.
  - W_IDLE: AW and W together -> W_RESP; AW only -> W_HAVE_A (address latched); W only -> W_HAVE_D (data and strobe latched).
  - W_HAVE_A: W handshake -> W_RESP. W_HAVE_D: AW handshake -> W_RESP.
  - Commit on the edge entering W_RESP: BVALID rises, register updates and wr_pulse[idx] asserts for exactly 1 cycle on that edge.
  - W_RESP: hold BVALID and BRESP until BREADY; then -> W_IDLE with BVALID=0. Only one write outstanding.
- Write data rules:
  - Normal register: byte k updated where WSTRB[k]=1.
  - RO register: no change, BRESP=OKAY, wr_pulse still asserted.
  - W1C register: reg <= (reg & ~(wdata & strobe_mask)) | hw_set_slice; set wins over clear on the same bit in the same cycle.
  - Out-of-range: no register change, BRESP=SLVERR, no wr_pulse.
  - W1C registers OR in hw_set every cycle, independent of bus activity.
- Read FSM states: R_IDLE, R_RESP.
  - ARREADY=1 only in R_IDLE.
  - On AR handshake, next edge: RVALID=1, RDATA = register (or reg_in slice for RO) as sampled in the handshake cycle; rd_pulse[idx] asserts for 1 cycle.
  - Out-of-range read: RDATA=0, RRESP=SLVERR, no pulse.
  - Hold RDATA/RRESP until RREADY, then -> R_IDLE.
  - Latency: RVALID 1 cycle after AR handshake; back-to-back reads every 2 cycles minimum.
- Concurrency: read and write channels are fully independent. A read accepted in the same cycle as a write commit to the same register returns the pre-write value.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC (WSTRB=F), read back -> 0x1..0x4, all OKAY; wr_pulse[0..3] each once.
- Reg1=0xAABBCCDD; write 0x11223344 WSTRB=0101 -> read 0xAA22CC44.
- AWVALID 3 cycles before WVALID, then WVALID 2 cycles before AWVALID -> both commit; BVALID 1 cycle after the later handshake; BREADY held 0 for 5 cycles keeps BVALID and BRESP stable.
- NUM_REGS=8: write/read 0x20 -> BRESP=SLVERR, RRESP=SLVERR, RDATA=0, no register changes.
- RO_MASK bit2, reg_in[2]=0xCAFEF00D; write 0x0 to 0x8 -> OKAY; read -> 0xCAFEF00D. W1C_MASK bit3, reg3=0xF0, write 0x30 with hw_set bit4 in same cycle -> 0xD0.
- Assert ARESETN=0 in W_HAVE_A and while RVALID=1 -> next cycle all valids 0, registers = RESET_VALUE; fresh write then succeeds.
